// File: rtl/debug_slave_sysclk_cmdq.sv
// System-clock side of the debug-slave bridge. It synchronises the JTAG update strobes and
// queues each captured {ir, sr} command. Every popped command is decoded into a one-cycle action pulse.
module debug_slave_sysclk_cmdq #(
    parameter int SR_WIDTH     = 38,
    parameter int IR_WIDTH     = 2,
    parameter int NUM_BRK      = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int FLUSH_ON_UIR = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [IR_WIDTH-1:0]               ir_in,
    input  logic [SR_WIDTH-1:0]               sr,
    input  logic                              vs_udr,
    input  logic                              vs_uir,
    output logic                              cmd_valid,
    input  logic                              cmd_ready,
    output logic [IR_WIDTH-1:0]               cmd_ir,
    output logic [SR_WIDTH-1:0]               cmd_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow,
    input  logic                              overflow_clr,
    output logic                              take_action_mem,
    output logic                              take_no_action_mem,
    output logic                              take_action_trace,
    output logic [NUM_BRK-1:0]                take_action_brk,
    output logic [NUM_BRK-1:0]                take_no_action_brk,
    output logic                              cmd_err
);
    localparam int CHW   = (NUM_BRK > 1) ? $clog2(NUM_BRK) : 1;
    localparam int PTRW  = $clog2(FIFO_DEPTH);
    localparam int LVLW  = $clog2(FIFO_DEPTH + 1);
    localparam int ENTW  = IR_WIDTH + SR_WIDTH;
    localparam int MASKW = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d, uir_sync_q, uir_sync_d;
    logic                   udr_prev_q, uir_prev_q;
    logic [MASKW-1:0]       mask_q, mask_d;
    logic [ENTW-1:0]        mem_q [FIFO_DEPTH];
    logic [ENTW-1:0]        mem_d [FIFO_DEPTH];
    logic [PTRW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LVLW-1:0]        level_q, level_d;
    logic                   overflow_q, overflow_d, cmd_err_q, cmd_err_d;
    logic                   act_mem_q, act_mem_d, noact_mem_q, noact_mem_d;
    logic                   act_trace_q, act_trace_d;
    logic [NUM_BRK-1:0]     act_brk_q, act_brk_d, noact_brk_q, noact_brk_d;

    logic                   udr_evt, uir_evt, flush, pop, full, drop, dec_en;
    logic [ENTW-1:0]        head;
    logic                   head_a;
    logic [CHW-1:0]         head_ch;

    assign udr_evt  = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q & (mask_q == '0);
    assign uir_evt  = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q & (mask_q == '0);
    assign flush    = (FLUSH_ON_UIR != 0) && uir_evt;
    assign full     = (level_q == LVLW'(FIFO_DEPTH));
    assign pop      = cmd_valid & cmd_ready;
    assign head     = mem_q[rd_ptr_q];
    assign head_a   = head[SR_WIDTH-1];
    assign head_ch  = head[SR_WIDTH-2 -: CHW];

    assign cmd_valid  = (level_q != '0);
    assign cmd_ir     = head[ENTW-1 -: IR_WIDTH];
    assign cmd_data   = head[SR_WIDTH-1:0];
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign cmd_err    = cmd_err_q;
    assign take_action_mem    = act_mem_q;
    assign take_no_action_mem = noact_mem_q;
    assign take_action_trace  = act_trace_q;
    assign take_action_brk    = act_brk_q;
    assign take_no_action_brk = noact_brk_q;

    // A flush discards the queue first, so a push arriving in the same cycle lands in slot 0.
    always_comb begin
        udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
        uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
        mask_d     = (mask_q != '0) ? mask_q - MASKW'(1) : mask_q;
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        drop       = 1'b0;
        dec_en     = 1'b0;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
            if (udr_evt) begin
                mem_d[0] = {ir_in, sr};
                wr_ptr_d = PTRW'(1);
                level_d  = LVLW'(1);
            end
        end else begin
            dec_en = pop;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTRW'(1);
            end
            if (udr_evt && full && !pop) begin
                drop = 1'b1;
            end else if (udr_evt) begin
                mem_d[wr_ptr_q] = {ir_in, sr};
                wr_ptr_d        = wr_ptr_q + PTRW'(1);
            end
            case ({udr_evt && !drop, pop})
                2'b10:   level_d = level_q + LVLW'(1);
                2'b01:   level_d = level_q - LVLW'(1);
                default: level_d = level_q;
            endcase
        end
        overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
    end

    // Pulses come from the entry leaving the queue; an out-of-range channel only flags cmd_err.
    always_comb begin
        act_mem_d   = 1'b0;
        noact_mem_d = 1'b0;
        act_trace_d = 1'b0;
        act_brk_d   = '0;
        noact_brk_d = '0;
        cmd_err_d   = overflow_clr ? 1'b0 : cmd_err_q;
        if (dec_en) begin
            if (int'(cmd_ir) == 0) begin
                act_mem_d   = head_a;
                noact_mem_d = ~head_a;
            end else if (int'(cmd_ir) == 2) begin
                if (int'(head_ch) >= NUM_BRK) begin
                    cmd_err_d = 1'b1;
                end
                for (int i = 0; i < NUM_BRK; i++) begin
                    if (int'(head_ch) == i) begin
                        act_brk_d[i]   = head_a;
                        noact_brk_d[i] = ~head_a;
                    end
                end
            end else if (int'(cmd_ir) == 3) begin
                act_trace_d = head_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            udr_sync_q  <= '0;
            uir_sync_q  <= '0;
            udr_prev_q  <= 1'b0;
            uir_prev_q  <= 1'b0;
            mask_q      <= MASKW'(SYNC_STAGES + 1);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            act_mem_q   <= 1'b0;
            noact_mem_q <= 1'b0;
            act_trace_q <= 1'b0;
            act_brk_q   <= '0;
            noact_brk_q <= '0;
        end else begin
            udr_sync_q  <= udr_sync_d;
            uir_sync_q  <= uir_sync_d;
            udr_prev_q  <= udr_sync_q[SYNC_STAGES-1];
            uir_prev_q  <= uir_sync_q[SYNC_STAGES-1];
            mask_q      <= mask_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            cmd_err_q   <= cmd_err_d;
            act_mem_q   <= act_mem_d;
            noact_mem_q <= noact_mem_d;
            act_trace_q <= act_trace_d;
            act_brk_q   <= act_brk_d;
            noact_brk_q <= noact_brk_d;
        end
    end
endmodule

// File: tb/tb_debug_slave_sysclk_cmdq.sv
// Bench for debug_slave_sysclk_cmdq: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_debug_slave_sysclk_cmdq;
    localparam int SR = 38;
    localparam int DEPTH = 4;
    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        reset, vs_udr, vs_uir, cmd_ready, overflow_clr;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        cmd_valid, overflow, cmd_err;
    logic [1:0]  cmd_ir;
    logic [37:0] cmd_data;
    logic [2:0]  fifo_level;
    logic        take_action_mem, take_no_action_mem, take_action_trace;
    logic [3:0]  take_action_brk, take_no_action_brk;

    logic        d5_cmd_valid, d5_overflow, d5_cmd_err;
    logic [1:0]  d5_cmd_ir;
    logic [37:0] d5_cmd_data;
    logic [2:0]  d5_fifo_level;
    logic        d5_am, d5_nam, d5_at;
    logic [4:0]  d5_ab, d5_nab;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    debug_slave_sysclk_cmdq #(.SR_WIDTH(38), .IR_WIDTH(2), .NUM_BRK(4), .FIFO_DEPTH(4),
                              .SYNC_STAGES(2), .FLUSH_ON_UIR(1)) dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr),
        .take_action_mem(take_action_mem), .take_no_action_mem(take_no_action_mem),
        .take_action_trace(take_action_trace), .take_action_brk(take_action_brk),
        .take_no_action_brk(take_no_action_brk), .cmd_err(cmd_err));

    // Five-channel instance so that a channel number beyond NUM_BRK is encodable.
    debug_slave_sysclk_cmdq #(.SR_WIDTH(38), .IR_WIDTH(2), .NUM_BRK(5), .FIFO_DEPTH(4),
                              .SYNC_STAGES(2), .FLUSH_ON_UIR(1)) dut5 (
        .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .cmd_valid(d5_cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(d5_cmd_ir), .cmd_data(d5_cmd_data),
        .fifo_level(d5_fifo_level), .overflow(d5_overflow), .overflow_clr(overflow_clr),
        .take_action_mem(d5_am), .take_no_action_mem(d5_nam), .take_action_trace(d5_at),
        .take_action_brk(d5_ab), .take_no_action_brk(d5_nab), .cmd_err(d5_cmd_err));

    typedef struct {
        logic [1:0] ir;
        logic       a;
        logic [1:0] ch;
        logic [10:0] exp_pulses;
    } vec_t;

    vec_t vecs[8];
    logic [1:0]  e_ir[8];
    logic [37:0] e_sr[8];

    function automatic logic [10:0] pulses();
        return {take_action_mem, take_no_action_mem, take_action_trace, take_action_brk, take_no_action_brk};
    endfunction

    function automatic logic [37:0] rand_sr();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[37:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic udrPulse(input logic [1:0] ir_v, input logic [37:0] sr_v);
        ir_in  = ir_v;
        sr     = sr_v;
        vs_udr = 1'b1;
        @(negedge clk);
        vs_udr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [37:0] s;
        s = rand_sr();
        s[37] = v.a;
        s[36:35] = v.ch;
        cmd_ready = 1'b1;
        ir_in  = v.ir;
        sr     = s;
        vs_udr = 1'b1;
        @(negedge clk);
        vs_udr = 1'b0;
        @(negedge clk);
        checkOutput("vec_valid_early", cmd_valid, 0);
        @(negedge clk);
        checkOutput("vec_valid_latency", cmd_valid, 1);
        checkOutput("vec_head", {cmd_ir, cmd_data}, {v.ir, s});
        @(negedge clk);
        checkOutput("vec_pulses", pulses(), v.exp_pulses);
        checkOutput("vec_drained", fifo_level, 0);
        @(negedge clk);
        checkOutput("vec_pulse_width", pulses(), 0);
    endtask

    // Reference decode straight from the command rules.
    function automatic void decode(input logic [1:0] ir_v, input logic [37:0] d,
                                   output logic [10:0] p, output logic err);
        int ch;
        logic a;
        a   = d[37];
        ch  = int'((d >> 35) % 4);
        p   = '0;
        err = 1'b0;
        if (ir_v == 2'd0) begin
            if (a) p[10] = 1'b1; else p[9] = 1'b1;
        end else if (ir_v == 2'd2) begin
            if (ch >= NB) err = 1'b1;
            else if (a) p[4 + ch] = 1'b1;
            else p[ch] = 1'b1;
        end else if (ir_v == 2'd3) begin
            if (a) p[8] = 1'b1;
        end
    endfunction

    logic [39:0] mq[$];
    logic [10:0] m_pulses;
    logic        m_ov, m_err;
    logic        h1, h2, h3, u1, u2, u3;
    int          ready_pct;

    initial begin
        reset = 1'b1; vs_udr = 1'b1; vs_uir = 1'b0; cmd_ready = 1'b0; overflow_clr = 1'b0;
        ir_in = 2'd0; sr = '0;
        vecs[0] = '{2'd0, 1'b1, 2'd0, 11'b100_0000_0000};
        vecs[1] = '{2'd0, 1'b0, 2'd1, 11'b010_0000_0000};
        vecs[2] = '{2'd1, 1'b1, 2'd2, 11'b000_0000_0000};
        vecs[3] = '{2'd2, 1'b0, 2'd3, 11'b000_0000_1000};
        vecs[4] = '{2'd2, 1'b1, 2'd0, 11'b000_0001_0000};
        vecs[5] = '{2'd2, 1'b1, 2'd2, 11'b000_0100_0000};
        vecs[6] = '{2'd3, 1'b1, 2'd1, 11'b001_0000_0000};
        vecs[7] = '{2'd3, 1'b0, 2'd0, 11'b000_0000_0000};

        // Strobe already high across reset must not produce a command.
        repeat (2) @(negedge clk);
        checkOutput("reset_level", fifo_level, 0);
        checkOutput("reset_outputs", {cmd_valid, overflow, cmd_err, pulses()}, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("held_udr_no_push", {cmd_valid, fifo_level}, 0);
        end
        vs_udr = 1'b0;
        repeat (3) @(negedge clk);
        e_sr[0] = rand_sr();
        udrPulse(2'd1, e_sr[0]);
        repeat (3) @(negedge clk);
        checkOutput("single_entry_level", fifo_level, 1);
        checkOutput("single_entry_head", {cmd_ir, cmd_data}, {2'd1, e_sr[0]});
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        checkOutput("single_entry_drain", fifo_level, 0);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
        cmd_ready = 1'b0;

        // Overflow: five commands into a four-deep queue.
        for (int i = 0; i < 5; i++) begin
            e_ir[i] = 2'(i % 4);
            e_sr[i] = rand_sr();
            udrPulse(e_ir[i], e_sr[i]);
        end
        checkOutput("ovf_level", fifo_level, 4);
        checkOutput("ovf_flag", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("ovf_drain_order", {cmd_ir, cmd_data}, {e_ir[i], e_sr[i]});
            cmd_ready = 1'b1;
            @(negedge clk);
        end
        cmd_ready = 1'b0;
        checkOutput("ovf_drained", {cmd_valid, fifo_level}, 0);
        checkOutput("ovf_sticky", overflow, 1);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        checkOutput("ovf_cleared", overflow, 0);

        // Flush and push arriving together.
        for (int i = 0; i < 3; i++) udrPulse(2'd1, rand_sr());
        checkOutput("flush_pre_level", fifo_level, 3);
        e_sr[0] = rand_sr();
        ir_in = 2'd3; sr = e_sr[0]; vs_udr = 1'b1; vs_uir = 1'b1;
        @(negedge clk);
        vs_udr = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("flush_level", fifo_level, 1);
        checkOutput("flush_head", {cmd_ir, cmd_data}, {2'd3, e_sr[0]});
        vs_uir = 1'b0;
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Full queue with a push and pop on the same edge.
        for (int i = 0; i < 4; i++) begin
            e_ir[i] = 2'd1;
            e_sr[i] = rand_sr();
            udrPulse(e_ir[i], e_sr[i]);
        end
        checkOutput("fullpp_pre", {overflow, fifo_level}, {1'b0, 3'd4});
        e_ir[4] = 2'd0;
        e_sr[4] = rand_sr();
        ir_in = e_ir[4]; sr = e_sr[4]; vs_udr = 1'b1;
        @(negedge clk);
        vs_udr = 1'b0;
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        checkOutput("fullpp_level", fifo_level, 4);
        checkOutput("fullpp_no_ovf", overflow, 0);
        for (int i = 1; i < 5; i++) begin
            checkOutput("fullpp_order", {cmd_ir, cmd_data}, {e_ir[i], e_sr[i]});
            cmd_ready = 1'b1;
            @(negedge clk);
        end
        cmd_ready = 1'b0;
        @(negedge clk);

        // Out-of-range breakpoint channel on the five-channel instance.
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        checkOutput("err_clear_start", d5_cmd_err, 0);
        cmd_ready = 1'b1;
        e_sr[0] = rand_sr();
        e_sr[0][37:34] = 4'b1101;
        udrPulse(2'd2, e_sr[0]);
        @(negedge clk);
        checkOutput("err_set", d5_cmd_err, 1);
        checkOutput("err_no_brk", {d5_ab, d5_nab}, 0);
        e_sr[0][37:34] = 4'b1100;
        udrPulse(2'd2, e_sr[0]);
        @(negedge clk);
        checkOutput("brk4_pulse", {d5_ab, d5_nab}, {5'b10000, 5'b00000});
        checkOutput("err_sticky", d5_cmd_err, 1);
        cmd_ready = 1'b0;
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        checkOutput("err_cleared", d5_cmd_err, 0);

        // Reset mid-stream drops queued commands and a pending pulse.
        udrPulse(2'd0, {1'b1, 37'h0});
        udrPulse(2'd0, {1'b1, 37'h1});
        checkOutput("mid_reset_pre", fifo_level, 2);
        cmd_ready = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_pulse", take_action_mem, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_clears", {pulses(), fifo_level, cmd_valid}, 0);
        reset = 1'b0;
        cmd_ready = 1'b0;
        repeat (5) @(negedge clk);

        // Randomized traffic against the reference queue model.
        mq.delete();
        m_pulses = '0; m_ov = 1'b0; m_err = 1'b0;
        h1 = 0; h2 = 0; h3 = 0; u1 = 0; u2 = 0; u3 = 0;
        ready_pct = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checkOutput("rnd_level", fifo_level, mq.size());
            checkOutput("rnd_valid", cmd_valid, mq.size() != 0);
            if (mq.size() != 0) checkOutput("rnd_head", {cmd_ir, cmd_data}, mq[0]);
            checkOutput("rnd_flags", {overflow, cmd_err}, {m_ov, m_err});
            checkOutput("rnd_pulses", pulses(), m_pulses);

            if (cyc % 200 == 0) ready_pct = (cyc / 200 % 3 == 0) ? 10 : ((cyc / 200 % 3 == 1) ? 50 : 90);
            if ($urandom_range(0, 2) == 0) vs_udr = ~vs_udr;
            if ($urandom_range(0, 19) == 0) vs_uir = ~vs_uir;
            cmd_ready    = ($urandom_range(0, 99) < ready_pct);
            overflow_clr = ($urandom_range(0, 15) == 0);
            ir_in        = 2'($urandom_range(0, 3));
            sr           = rand_sr();

            begin
                logic push, fl, pop, drop, derr, was_full;
                logic [39:0] hd;
                logic [10:0] p;
                push = h2 & ~h3;
                fl   = u2 & ~u3;
                pop  = (mq.size() != 0) && cmd_ready;
                was_full = (mq.size() == DEPTH);
                drop = 1'b0;
                derr = 1'b0;
                p    = '0;
                if (fl) begin
                    mq.delete();
                    if (push) mq.push_back({ir_in, sr});
                end else begin
                    if (pop) begin
                        hd = mq.pop_front();
                        decode(hd[39:38], hd[37:0], p, derr);
                    end
                    if (push) begin
                        if (was_full && !pop) drop = 1'b1;
                        else mq.push_back({ir_in, sr});
                    end
                end
                m_pulses = p;
                m_ov  = drop ? 1'b1 : (overflow_clr ? 1'b0 : m_ov);
                m_err = derr ? 1'b1 : (overflow_clr ? 1'b0 : m_err);
                h3 = h2; h2 = h1; h1 = vs_udr;
                u3 = u2; u2 = u1; u1 = vs_uir;
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
